// File: rtl/spi_master_ctrl.sv
// SPI master: turns 10-bit command words into SPI frames on SS_n/MOSI and
// returns the MISO byte for read-data commands. Link runs on the system clock.
module spi_master_ctrl #(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned IDLE_GAP    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int unsigned CW = 4;
    localparam int unsigned SW = 3;

    localparam logic [SW-1:0] S_IDLE  = 3'd0;
    localparam logic [SW-1:0] S_START = 3'd1;
    localparam logic [SW-1:0] S_SHIFT = 3'd2;
    localparam logic [SW-1:0] S_TURN  = 3'd3;
    localparam logic [SW-1:0] S_RECV  = 3'd4;
    localparam logic [SW-1:0] S_GAP   = 3'd5;

    localparam logic [CW-1:0] SHIFT_LAST = CW'(9);
    localparam logic [CW-1:0] RECV_LAST  = CW'(7);
    localparam logic [CW-1:0] TURN_LAST  = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(IDLE_GAP - 1);

    logic [SW-1:0] state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [9:0]    cmd_reg, cmd_reg_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [7:0]    rsp_data_nxt;
    logic          cmd_ready_nxt, rsp_valid_nxt, busy_nxt, ss_n_nxt, mosi_nxt;

    // State and all outputs are registered from the next-state logic below
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cmd_reg   <= '0;
            shreg     <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cmd_reg   <= cmd_reg_nxt;
            shreg     <= shreg_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_valid <= rsp_valid_nxt;
            cmd_ready <= cmd_ready_nxt;
            busy      <= busy_nxt;
            SS_n      <= ss_n_nxt;
            MOSI      <= mosi_nxt;
        end
    end

    // Next state plus the output values for the cycle that follows
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cmd_reg_nxt   = cmd_reg;
        shreg_nxt     = shreg;
        rsp_data_nxt  = rsp_data;
        rsp_valid_nxt = 1'b0;
        cmd_ready_nxt = cmd_ready;
        busy_nxt      = busy;
        ss_n_nxt      = SS_n;
        mosi_nxt      = MOSI;

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_reg_nxt   = cmd_data;
                    state_nxt     = S_START;
                    cmd_ready_nxt = 1'b0;
                    busy_nxt      = 1'b1;
                    ss_n_nxt      = 1'b0;
                    mosi_nxt      = cmd_data[9];
                end
            end
            S_START: begin
                state_nxt = S_SHIFT;
                cnt_nxt   = '0;
                mosi_nxt  = cmd_reg[9];
            end
            S_SHIFT: begin
                cnt_nxt = '0;
                if (cnt == SHIFT_LAST) begin
                    mosi_nxt = 1'b0;
                    if (cmd_reg[9:8] == 2'b11) begin
                        state_nxt = S_TURN;
                    end else begin
                        state_nxt = S_GAP;
                        ss_n_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt  = cnt + CW'(1);
                    mosi_nxt = cmd_reg[CW'(8) - cnt];
                end
            end
            S_TURN: begin
                if (cnt == TURN_LAST) begin
                    state_nxt = S_RECV;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_RECV: begin
                shreg_nxt = {shreg[6:0], MISO};
                if (cnt == RECV_LAST) begin
                    rsp_data_nxt  = {shreg[6:0], MISO};
                    rsp_valid_nxt = 1'b1;
                    ss_n_nxt      = 1'b1;
                    state_nxt     = S_GAP;
                    cnt_nxt       = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt     = S_IDLE;
                    cnt_nxt       = '0;
                    cmd_ready_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt     = S_IDLE;
                cnt_nxt       = '0;
                cmd_ready_nxt = 1'b1;
                busy_nxt      = 1'b0;
                ss_n_nxt      = 1'b1;
                mosi_nxt      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: table-driven frames plus
// hand-written back-to-back, reset-in-RECV and data-change sequences.
module tb_spi_master_ctrl;

    localparam int unsigned IDLE_GAP = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_data = '0;
    logic       MISO = 1'b0;
    logic       sel = 1'b0;

    logic       v0, v1;
    logic       rdy0, rv0, busy0, ss0, mosi0;
    logic       rdy1, rv1, busy1, ss1, mosi1;
    logic [7:0] rsp0, rsp1;
    logic       o_ready, o_rv, o_busy, o_ssn, o_mosi;
    logic [7:0] o_rsp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] cmd;
        logic [7:0] miso;
        logic       sel;
        int         len;
        logic       rv;
        logic [7:0] rsp;
    } vec_t;

    assign v0 = cmd_valid & ~sel;
    assign v1 = cmd_valid & sel;
    assign o_ready = sel ? rdy1  : rdy0;
    assign o_rv    = sel ? rv1   : rv0;
    assign o_busy  = sel ? busy1 : busy0;
    assign o_ssn   = sel ? ss1   : ss0;
    assign o_mosi  = sel ? mosi1 : mosi0;
    assign o_rsp   = sel ? rsp1  : rsp0;

    spi_master_ctrl #(.TURN_CYCLES(2), .IDLE_GAP(IDLE_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_data(cmd_data),
        .rsp_valid(rv0), .rsp_data(rsp0), .busy(busy0), .SS_n(ss0), .MOSI(mosi0), .MISO(MISO)
    );

    spi_master_ctrl #(.TURN_CYCLES(3), .IDLE_GAP(IDLE_GAP)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_data(cmd_data),
        .rsp_valid(rv1), .rsp_data(rsp1), .busy(busy1), .SS_n(ss1), .MOSI(mosi1), .MISO(MISO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one command, plays MISO during RECV, checks the frame and the gap.
    // Returns at the negedge where cmd_ready is seen high again.
    task automatic run_frame(input string tag, input vec_t v, input bit keep,
                             input logic [9:0] nxt, input bit corrupt);
        int k, n, g, pulses, turn;
        logic [10:0] got_mosi, exp_mosi;
        logic [7:0] got_rsp;
        bit tail_bad, busy_bad, hi_bad, rv_first;
        turn = v.sel ? 3 : 2;
        sel = v.sel;
        cmd_valid = 1'b1;
        cmd_data = v.cmd;
        n = 0;
        while (!o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready_wait"}, 32'(o_ready), 32'd1);
        @(negedge clk);
        cmd_valid = keep;
        cmd_data = corrupt ? ~v.cmd : (keep ? nxt : v.cmd);
        k = 0; pulses = 0; got_mosi = '0; got_rsp = '0;
        tail_bad = 0; busy_bad = 0; hi_bad = 0; rv_first = 0;
        while (o_ssn == 1'b0 && k < 40) begin
            if (k < 11) got_mosi[10 - k] = o_mosi;
            else if (o_mosi !== 1'b0) tail_bad = 1;
            if (o_rv) pulses++;
            if (!o_busy || o_ready) busy_bad = 1;
            if (k >= 11 + turn && k < 19 + turn) MISO = v.miso[7 - (k - 11 - turn)];
            else MISO = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        exp_mosi = {v.cmd[9], v.cmd};
        check({tag, " frame_len"}, 32'(k), 32'(v.len));
        check({tag, " mosi_seq"}, 32'(got_mosi), 32'(exp_mosi));
        check({tag, " mosi_tail_zero"}, 32'(tail_bad), 32'd0);
        check({tag, " busy_in_frame"}, 32'(busy_bad), 32'd0);
        g = 0;
        while (!o_ready && g < 40) begin
            if (o_rv) begin
                pulses++;
                got_rsp = o_rsp;
                if (g == 0) rv_first = 1;
            end
            if (o_ssn !== 1'b1 || o_mosi !== 1'b0) hi_bad = 1;
            if (!o_busy) busy_bad = 1;
            MISO = 1'($urandom_range(0, 1));
            @(negedge clk);
            g++;
        end
        check({tag, " gap_len"}, 32'(g), 32'(IDLE_GAP));
        check({tag, " gap_lines"}, 32'(hi_bad), 32'd0);
        check({tag, " idle_ss_busy_rv"}, {29'd0, o_ssn, o_busy, o_rv}, 32'b100);
        check({tag, " rsp_pulses"}, 32'(pulses), 32'(v.rv));
        if (v.rv) begin
            check({tag, " rsp_first_gap"}, 32'(rv_first), 32'd1);
            check({tag, " rsp_data"}, 32'(got_rsp), 32'(v.rsp));
            check({tag, " rsp_hold"}, 32'(o_rsp), 32'(v.rsp));
        end
    endtask

    vec_t vecs[9];
    vec_t q[4];
    vec_t wv;
    bit bad;

    initial begin
        // cmd, miso, sel(TURN=3 instance), SS_n-low cycles, rsp_valid, rsp_data
        vecs[0] = '{10'h03C, 8'h00, 1'b0, 11, 1'b0, 8'h00};
        vecs[1] = '{10'h010, 8'h00, 1'b0, 11, 1'b0, 8'h00};
        vecs[2] = '{10'h1A5, 8'h00, 1'b0, 11, 1'b0, 8'h00};
        vecs[3] = '{10'h210, 8'h00, 1'b0, 11, 1'b0, 8'h00};
        vecs[4] = '{10'h300, 8'hA5, 1'b0, 21, 1'b1, 8'hA5};
        vecs[5] = '{10'h3FF, 8'h3C, 1'b0, 21, 1'b1, 8'h3C};
        vecs[6] = '{10'h2C3, 8'hFF, 1'b0, 11, 1'b0, 8'h00};
        vecs[7] = '{10'h300, 8'h00, 1'b0, 21, 1'b1, 8'h00};
        vecs[8] = '{10'h300, 8'hFF, 1'b1, 22, 1'b1, 8'hFF};

        do_reset();
        check("reset_outputs", {23'd0, o_ssn, o_mosi, o_ready, o_rv, o_busy, 3'd0}, {23'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
        check("reset_rsp_data", 32'(o_rsp), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i], 1'b0, 10'd0, 1'b0);
            cmd_valid = 1'b0;
            @(negedge clk);
        end
        sel = 1'b0;

        // Four queued commands with cmd_valid held throughout
        q[0] = '{10'h055, 8'h00, 1'b0, 11, 1'b0, 8'h00};
        q[1] = '{10'h1AA, 8'h00, 1'b0, 11, 1'b0, 8'h00};
        q[2] = '{10'h200, 8'h00, 1'b0, 11, 1'b0, 8'h00};
        q[3] = '{10'h3C3, 8'h5A, 1'b0, 21, 1'b1, 8'h5A};
        for (int i = 0; i < 4; i++)
            run_frame($sformatf("queue%0d", i), q[i], i < 3, (i < 3) ? q[(i + 1) % 4].cmd : 10'd0, 1'b0);
        bad = 0;
        repeat (5) begin
            if (o_ssn !== 1'b1 || o_busy !== 1'b0) bad = 1;
            @(negedge clk);
        end
        check("queue_no_extra_frame", 32'(bad), 32'd0);

        // Changing cmd_data while busy must not affect the frame
        wv = '{10'h26B, 8'h00, 1'b0, 11, 1'b0, 8'h00};
        run_frame("data_change", wv, 1'b0, 10'd0, 1'b1);
        wv = '{10'h36B, 8'h96, 1'b0, 21, 1'b1, 8'h96};
        run_frame("data_change_rd", wv, 1'b0, 10'd0, 1'b1);

        // Reset during the 4th RECV cycle of a read-data frame
        sel = 1'b0;
        cmd_valid = 1'b1;
        cmd_data = 10'h300;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (16) begin
            MISO = 1'b1;
            @(negedge clk);
        end
        check("rst_pre_ss_low", 32'(o_ssn), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ss_mosi", {30'd0, o_ssn, o_mosi}, 32'b10);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_rv !== 1'b0 || o_ssn !== 1'b1) bad = 1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (o_rv !== 1'b0) bad = 1;
        end
        check("rst_no_rsp", 32'(bad), 32'd0);
        check("rst_ready_idle", {30'd0, o_ready, o_busy}, 32'b10);
        wv = '{10'h0C7, 8'h00, 1'b0, 11, 1'b0, 8'h00};
        run_frame("after_rst", wv, 1'b0, 10'd0, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
